// File: rtl/mul_div_control_unit_if.sv
// Control interface between the MUL/DIV sequencer and the datapath.
// Ports: start/md_ready/ir_q flow into the sequencer; enable/bus_select/md_read/alu_op
//        and the busy/done/illegal status flow out of it.
interface mul_div_control_unit_if;
   logic        start;       // launch one instruction (honoured only when idle)
   logic        md_ready;    // memory data valid during the T1 read
   logic [31:0] ir_q;        // IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb
   logic [31:0] enable;      // register load enables
   logic [31:0] bus_select;  // one-hot bus driver select
   logic        md_read;     // MDR loads memory data instead of bus
   logic [3:0]  alu_op;      // ALU operation select
   logic        busy;        // sequencer not idle
   logic        done;        // completion pulse
   logic        illegal;     // unsupported-opcode pulse

   // Sequencer side (initiator of the datapath controls)
   modport master (
      input  start, md_ready, ir_q,
      output enable, bus_select, md_read, alu_op, busy, done, illegal
   );

   // Datapath / CPU sequencer side
   modport slave (
      output start, md_ready, ir_q,
      input  enable, bus_select, md_read, alu_op, busy, done, illegal
   );
endinterface

// File: rtl/mul_div_control_unit.sv
// Hardwired MUL/DIV control sequencer: fetch T0-T2, execute T3-T6, then DONE.
// Latency: 9 cycles from start edge to end of done pulse, +1 per T1 memory wait cycle.
// Backpressure: md_ready low holds T1 indefinitely; start is ignored (not queued) while busy.
// Ports: clk, clr (synchronous active-high reset); bus_if (master) carries start, md_ready,
//        ir_q in and enable, bus_select, md_read, alu_op, busy, done, illegal out.
module mul_div_control_unit #(
   parameter logic [4:0] OP_MUL  = 5'b01111,
   parameter logic [4:0] OP_DIV  = 5'b10000,
   parameter logic [3:0] ALU_MUL = 4'd12,
   parameter logic [3:0] ALU_DIV = 4'd13
) (
   input logic                    clk,
   input logic                    clr,
   mul_div_control_unit_if.master bus_if
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
   } state_t;

   state_t     state_q;
   logic [4:0] opcode;
   logic [3:0] ra;
   logic [3:0] rb;
   logic       legal;
   logic       unused_ir;

   assign opcode    = bus_if.ir_q[31:27];
   assign ra        = bus_if.ir_q[26:23];
   assign rb        = bus_if.ir_q[22:19];
   assign legal     = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign unused_ir = ^bus_if.ir_q[18:0];

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (bus_if.start) state_q <= S_T0;
            S_T0:    state_q <= S_T1;
            S_T1:    if (bus_if.md_ready) state_q <= S_T2;
            S_T2:    state_q <= S_T3;
            S_T3:    state_q <= legal ? S_T4 : S_IDLE;
            S_T4:    state_q <= S_T5;
            S_T5:    state_q <= S_T6;
            S_T6:    state_q <= S_DONE;
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs are a pure decode of the present state. The Ra/Rb/opcode-dependent
   // steps (T3/T4) cannot be precomputed a cycle early because IR is only loaded
   // at the end of T2, so the decode reads ir_q live during those states.
   always_comb begin
      bus_if.enable     = '0;
      bus_if.bus_select = '0;
      bus_if.md_read    = 1'b0;
      bus_if.alu_op     = '0;
      bus_if.busy       = (state_q != S_IDLE);
      bus_if.done       = 1'b0;
      bus_if.illegal    = 1'b0;
      case (state_q)
         S_T0: begin
            bus_if.bus_select[20] = 1'b1;   // PC onto bus
            bus_if.enable[25]     = 1'b1;   // MAR <- PC
            bus_if.enable[20]     = 1'b1;   // PC increment
         end
         S_T1: begin
            bus_if.md_read    = 1'b1;
            bus_if.enable[21] = 1'b1;       // MDR <- memory
         end
         S_T2: begin
            bus_if.bus_select[21] = 1'b1;   // MDR onto bus
            bus_if.enable[23]     = 1'b1;   // IR <- MDR
         end
         S_T3: begin
            if (legal) begin
               bus_if.bus_select[ra] = 1'b1;
               bus_if.enable[27]     = 1'b1;   // Y <- Ra
            end else begin
               bus_if.illegal = 1'b1;
            end
         end
         S_T4: begin
            bus_if.bus_select[rb] = 1'b1;
            bus_if.enable[24]     = 1'b1;      // Z <- Y op Rb
            if (opcode == OP_MUL)      bus_if.alu_op = ALU_MUL;
            else if (opcode == OP_DIV) bus_if.alu_op = ALU_DIV;
         end
         S_T5: begin
            bus_if.bus_select[19] = 1'b1;   // Zlow onto bus
            bus_if.enable[17]     = 1'b1;   // LO
         end
         S_T6: begin
            bus_if.bus_select[18] = 1'b1;   // Zhigh onto bus
            bus_if.enable[16]     = 1'b1;   // HI
         end
         S_DONE:  bus_if.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mul_div_control_unit.sv
// Self-checking bench for mul_div_control_unit: directed table, memory-wait latency
// sequence and randomized instructions against a trace-level reference model.
module tb_mul_div_control_unit;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   mul_div_control_unit_if dut_if ();

   mul_div_control_unit dut (
      .clk    (clk),
      .clr    (clr),
      .bus_if (dut_if)
   );

   typedef struct packed {
      logic [31:0] en;
      logic [31:0] bus;
      logic        mdr;
      logic [3:0]  alu;
      logic        busy;
      logic        done;
      logic        ill;
   } out_t;

   typedef struct packed {
      logic        clr;
      logic        start;
      logic        md_ready;
      logic [31:0] ir;
      out_t        exp;
   } vec_t;

   localparam logic [31:0] IR_MUL = 32'h7B38_0000;  // MUL R6,R7
   localparam logic [31:0] IR_DIV = 32'h8119_0000;  // DIV R2,R3
   localparam logic [31:0] IR_BAD = 32'h0000_0000;

   localparam out_t O_IDLE = {32'h0, 32'h0, 1'b0, 4'd0, 3'b000};
   localparam out_t O_T0   = {32'h0210_0000, 32'h0010_0000, 1'b0, 4'd0, 3'b100};
   localparam out_t O_T1   = {32'h0020_0000, 32'h0, 1'b1, 4'd0, 3'b100};
   localparam out_t O_T2   = {32'h0080_0000, 32'h0020_0000, 1'b0, 4'd0, 3'b100};
   localparam out_t O_T5   = {32'h0002_0000, 32'h0008_0000, 1'b0, 4'd0, 3'b100};
   localparam out_t O_T6   = {32'h0001_0000, 32'h0004_0000, 1'b0, 4'd0, 3'b100};
   localparam out_t O_DONE = {32'h0, 32'h0, 1'b0, 4'd0, 3'b110};
   localparam out_t O_ILL  = {32'h0, 32'h0, 1'b0, 4'd0, 3'b101};
   localparam out_t O_MT3  = {32'h0800_0000, 32'h0000_0040, 1'b0, 4'd0, 3'b100};
   localparam out_t O_MT4  = {32'h0100_0000, 32'h0000_0080, 1'b0, 4'd12, 3'b100};
   localparam out_t O_DT3  = {32'h0800_0000, 32'h0000_0004, 1'b0, 4'd0, 3'b100};
   localparam out_t O_DT4  = {32'h0100_0000, 32'h0000_0008, 1'b0, 4'd13, 3'b100};

   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t tbl[$];
   out_t exp_q[$];

   function automatic vec_t v(input logic c, input logic s, input logic m,
                              input logic [31:0] ir, input out_t e);
      vec_t r;
      r.clr = c; r.start = s; r.md_ready = m; r.ir = ir; r.exp = e;
      return r;
   endfunction

   task automatic step(input logic c, input logic s, input logic m, input logic [31:0] ir);
      clr            = c;
      dut_if.start    = s;
      dut_if.md_ready = m;
      dut_if.ir_q     = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input out_t e);
      out_t a;
      a = {dut_if.enable, dut_if.bus_select, dut_if.md_read, dut_if.alu_op,
           dut_if.busy, dut_if.done, dut_if.illegal};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got en=%h bus=%h mdr=%b alu=%0d busy=%b done=%b ill=%b, want en=%h bus=%h mdr=%b alu=%0d busy=%b done=%b ill=%b",
                    name, a.en, a.bus, a.mdr, a.alu, a.busy, a.done, a.ill,
                    e.en, e.bus, e.mdr, e.alu, e.busy, e.done, e.ill);
   endtask

   // Reference model: expected per-cycle output trace of one instruction, starting
   // with the cycle after the start edge and ending with the first idle cycle.
   task automatic build(input logic [31:0] ir, input int waits);
      logic [4:0]  op;
      logic [31:0] one;
      int          ra;
      int          rb;
      op  = ir[31:27];
      ra  = int'(ir[26:23]);
      rb  = int'(ir[22:19]);
      one = 32'h1;
      exp_q = {};
      exp_q.push_back(O_T0);
      repeat (waits + 1) exp_q.push_back(O_T1);
      exp_q.push_back(O_T2);
      if (op == 5'b01111 || op == 5'b10000) begin
         exp_q.push_back({one << 27, one << ra, 1'b0, 4'd0, 3'b100});
         exp_q.push_back({one << 24, one << rb, 1'b0, (op == 5'b01111) ? 4'd12 : 4'd13, 3'b100});
         exp_q.push_back(O_T5);
         exp_q.push_back(O_T6);
         exp_q.push_back(O_DONE);
      end else begin
         exp_q.push_back(O_ILL);
      end
      exp_q.push_back(O_IDLE);
   endtask

   initial begin
      logic [31:0] ir;
      logic        s;
      logic        m;
      int          sel;
      int          w;
      int          done_cyc;

      clr = 1'b1; dut_if.start = 1'b0; dut_if.md_ready = 1'b0; dut_if.ir_q = '0;

      // MUL happy path
      tbl.push_back(v(1, 0, 1, IR_MUL, O_IDLE));
      tbl.push_back(v(0, 1, 1, IR_MUL, O_T0));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T1));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T2));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_MT3));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_MT4));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T5));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T6));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_DONE));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_IDLE));
      // DIV with 3 memory wait cycles and start pulses in T2 and T5
      tbl.push_back(v(0, 1, 0, IR_DIV, O_T0));
      tbl.push_back(v(0, 0, 0, IR_DIV, O_T1));
      tbl.push_back(v(0, 0, 0, IR_DIV, O_T1));
      tbl.push_back(v(0, 0, 0, IR_DIV, O_T1));
      tbl.push_back(v(0, 0, 0, IR_DIV, O_T1));
      tbl.push_back(v(0, 0, 1, IR_DIV, O_T2));
      tbl.push_back(v(0, 1, 1, IR_DIV, O_DT3));
      tbl.push_back(v(0, 0, 1, IR_DIV, O_DT4));
      tbl.push_back(v(0, 0, 1, IR_DIV, O_T5));
      tbl.push_back(v(0, 1, 1, IR_DIV, O_T6));
      tbl.push_back(v(0, 0, 1, IR_DIV, O_DONE));
      tbl.push_back(v(0, 0, 1, IR_DIV, O_IDLE));
      tbl.push_back(v(0, 0, 1, IR_DIV, O_IDLE));
      // Illegal opcode
      tbl.push_back(v(0, 1, 1, IR_BAD, O_T0));
      tbl.push_back(v(0, 0, 1, IR_BAD, O_T1));
      tbl.push_back(v(0, 0, 1, IR_BAD, O_T2));
      tbl.push_back(v(0, 0, 1, IR_BAD, O_ILL));
      tbl.push_back(v(0, 0, 1, IR_BAD, O_IDLE));
      tbl.push_back(v(0, 0, 1, IR_BAD, O_IDLE));
      // Reset at T4, then clr+start together, then a full MUL
      tbl.push_back(v(0, 1, 1, IR_MUL, O_T0));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T1));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T2));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_MT3));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_MT4));
      tbl.push_back(v(1, 0, 1, IR_MUL, O_IDLE));
      tbl.push_back(v(1, 1, 1, IR_MUL, O_IDLE));
      tbl.push_back(v(0, 1, 1, IR_MUL, O_T0));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T1));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T2));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_MT3));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_MT4));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T5));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_T6));
      tbl.push_back(v(0, 0, 1, IR_MUL, O_DONE));
      // start held high re-launches in the idle cycle after DONE
      tbl.push_back(v(0, 1, 1, IR_MUL, O_IDLE));
      tbl.push_back(v(0, 1, 1, IR_MUL, O_T0));
      tbl.push_back(v(1, 0, 1, IR_MUL, O_IDLE));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].clr, tbl[i].start, tbl[i].md_ready, tbl[i].ir);
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Memory wait of 2 cycles: done must appear in cycle 10 after start
      step(0, 1, 1, IR_MUL);
      done_cyc = 0;
      for (int cyc = 2; cyc <= 40; cyc++) begin
         step(0, 0, (cyc == 3 || cyc == 4) ? 1'b0 : 1'b1, IR_MUL);
         if (dut_if.done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
      end
      n_checks++;
      if (done_cyc == 10) n_pass++;
      else $display("FAIL wait_latency: done in cycle %0d, want cycle 10 (0 = never)", done_cyc);
      step(0, 0, 1, IR_MUL);
      check("wait_idle", O_IDLE);

      // Randomized instructions against the trace model
      for (int n = 0; n < 80; n++) begin
         sel = int'($urandom_range(0, 2));
         ir  = $urandom;
         w   = int'($urandom_range(0, 4));
         if (sel == 0)      ir[31:27] = 5'b01111;
         else if (sel == 1) ir[31:27] = 5'b10000;
         build(ir, w);
         for (int j = 0; j < exp_q.size(); j++) begin
            s = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (j >= 2 && j <= 1 + w) m = 1'b0;
            else if (j == 2 + w)      m = 1'b1;
            else                      m = 1'($urandom_range(0, 1));
            step(0, s, m, ir);
            check($sformatf("rand%0d.%0d", n, j), exp_q[j]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
